// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key debounce encoder
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int          KEY_NUM                 = 4;
    localparam logic [3:0]  KEY_IDLE                = 4'b1111;
    localparam int          DEBOUNCE_CYCLES_DEFAULT = 200000;

    // Keys are active-low; the lowest-numbered pressed key wins.
    function automatic logic [1:0] lowest_zero_index(input logic [KEY_NUM-1:0] keys);
        lowest_zero_index = 2'd0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (!keys[i]) begin
                lowest_zero_index = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer bus, resets to all ones
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '1;
            q      <= '1;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/key_debounce_encoder.sv
// rtl/key_debounce_encoder.sv - debounces four active-low keys and encodes the accepted index
module key_debounce_encoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST_N,
    input  logic       EN,
    input  logic [3:0] Key_In,
    output logic [1:0] Key_Out,
    output logic       Key_Valid
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_key;
    key_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       snapshot, snapshot_next;
    logic [1:0]       key_out_next;
    logic             key_valid_next;

    key_sync #(.WIDTH(KEY_NUM)) u_key_sync (
        .clk   (Sys_CLK),
        .rst_n (Sys_RST_N),
        .d     (Key_In),
        .q     (sync_key)
    );

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            snapshot  <= KEY_IDLE;
            Key_Out   <= 2'd0;
            Key_Valid <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            snapshot  <= snapshot_next;
            Key_Out   <= key_out_next;
            Key_Valid <= key_valid_next;
        end
    end

    // Counter compares against CNT_LAST before incrementing, so it never wraps.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        snapshot_next  = snapshot;
        key_out_next   = Key_Out;
        key_valid_next = 1'b0;

        if (!EN) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync_key != KEY_IDLE) begin
                        snapshot_next = sync_key;
                        cnt_next      = '0;
                        state_next    = PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_key != snapshot) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next     = HELD;
                        cnt_next       = '0;
                        key_out_next   = lowest_zero_index(snapshot);
                        key_valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (sync_key == KEY_IDLE) begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_key != KEY_IDLE) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/key_debounce_encoder.md
KEY_DEBOUNCE_ENCODER -- requirements
Module: key_debounce_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 200000, number of stable Sys_CLK cycles required to accept a press or release (20 ms at 10 MHz); legal range >= 2.
REQ-002 Sys_CLK  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-003 Sys_RST_N  input  1  reset; asynchronous assert, active-low.
REQ-004 EN  input  1  enable; low holds the FSM idle and suppresses new key events.
REQ-005 Key_In  input  4  raw push-buttons; active-low; asynchronous to Sys_CLK; bouncing.
REQ-006 Key_Out  output  2  encoded index (0-3) of the last accepted key; feeds the nixie-tube display stage directly.
REQ-007 Key_Valid  output  1  single-cycle pulse on the cycle Key_Out takes a newly accepted value.

Function
REQ-008 Key_In SHALL pass through a 2-flop synchronizer per bit (reset value 1'b1) before any other logic uses it; the synchronizer output is called sync_key.
REQ-009 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-010 IDLE: if EN=1 and sync_key != 4'b1111, the FSM SHALL latch sync_key into snapshot, clear the counter to 0 and enter PRESS_WAIT.
REQ-011 PRESS_WAIT: each cycle, sync_key == snapshot with counter < DEBOUNCE_CYCLES-1 -> counter +1; sync_key != snapshot -> IDLE, counter cleared, no event.
REQ-012 PRESS_WAIT with sync_key == snapshot and counter == DEBOUNCE_CYCLES-1 -> HELD; on that same edge Key_Out SHALL load the index of the lowest-numbered 0 bit in snapshot, and Key_Valid SHALL be high for exactly the following cycle.
REQ-013 Simultaneous presses: priority to the lowest index (snapshot 4'b0101 -> Key_Out=2'd1).
REQ-014 HELD: sync_key == 4'b1111 -> counter cleared, RELEASE_WAIT; otherwise stay (changes among held keys ignored).
REQ-015 RELEASE_WAIT: any 0 bit in sync_key -> HELD, counter cleared; all ones for DEBOUNCE_CYCLES consecutive cycles -> IDLE; no Key_Valid on release.
REQ-016 Latency: with Key_In stable from before edge k, Key_Valid SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2 (edges k, k+1 synchronize; edge k+2 enters PRESS_WAIT).
REQ-017 EN=0 in any state SHALL force IDLE synchronously on the next edge, clear the counter, hold Key_Out, and keep Key_Valid low.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); it SHALL never wrap (compare-then-transition at DEBOUNCE_CYCLES-1).
REQ-019 Key_Out SHALL hold its value indefinitely between accepted presses; Key_Valid SHALL never be high on two consecutive cycles.

Reset
REQ-020 Sys_RST_N low SHALL immediately force: state IDLE, counter 0, snapshot 4'b1111, synchronizer flops 1'b1, Key_Out 2'd0, Key_Valid 0.
REQ-021 Reset asserted mid-debounce or while HELD SHALL discard the pending event; after release a still-held key SHALL require a full new debounce before Key_Valid.
REQ-022 Reset deassertion SHALL be synchronized externally; no output may glitch high on deassertion.

Structure
REQ-023 Shared package key_pkg SHALL hold the state enumeration (2-bit encoding), KEY_NUM=4, KEY_IDLE=4'b1111 and the DEBOUNCE_CYCLES default.
REQ-024 One sub-module, key_sync (parameterised-width 2-flop synchronizer with async active-low reset), SHALL be instantiated once for the 4-bit bus.
REQ-025 All outputs SHALL be registered; no combinational path from Key_In to any output.

Verification (DEBOUNCE_CYCLES=8, 10 MHz Sys_CLK)
REQ-026 Clean press: Key_In 1111->1011 held 20 cycles -> Key_Valid 1-cycle pulse 10 edges after first sampling edge, Key_Out=2'd2.
REQ-027 Bounce: Key_In toggles 1110/1111 every 3 cycles for 30 cycles then stable 1110 -> exactly one Key_Valid, Key_Out=2'd0, none during bouncing.
REQ-028 Simultaneous: Key_In=0110 stable -> Key_Out=2'd0; then release 20 cycles, Key_In=1001 stable -> Key_Out=2'd1, two pulses total.
REQ-029 Release bounce: held key released with 2-cycle 0 glitch inside RELEASE_WAIT -> back to HELD, no extra Key_Valid, Key_Out unchanged.
REQ-030 EN/reset: EN=0 during PRESS_WAIT at counter=5 -> no pulse, Key_Out unchanged; Sys_RST_N pulsed low while HELD -> Key_Out=0 at once, key still held after release yields one new pulse after full debounce.
